risc_core_mc: RTL and testbench
===============================

Name: risc_core_mc

Overview:
Parametrised multi-cycle successor to the single-cycle 8-bit RISC core. It has a configurable data width and PC width, and uses req/ack handshakes for instruction and data memory so that wait-state memories can be attached. It adds a hardwired-zero R0, plus branch-if-zero, add-immediate and halt instructions. It sits between the program ROM and the data RAM/I/O subsystem.

Parameters:
DATA_W, 8, register/ALU/data-bus width; legal values 8..32.
ADDR_W, 8, PC and instruction address width; legal values 8..16. Jump/branch targets are imm zero-extended to ADDR_W.
IO_ADDR, {DATA_W{1'b1}}, data address routed to io_in/io_out instead of dmem.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
imem_req  out  1  instruction fetch request
imem_addr  out  ADDR_W  fetch address (= pc)
imem_rdata  in  16  instruction word, valid when imem_ack=1
imem_ack  in  1  fetch complete
dmem_req  out  1  data access request
dmem_we  out  1  1=store, 0=load
dmem_addr  out  DATA_W  data address
dmem_wdata  out  DATA_W  store data
dmem_rdata  in  DATA_W  load data, valid when dmem_ack=1
dmem_ack  in  1  data access complete
io_in  in  DATA_W  external input, read at IO_ADDR
io_out  out  DATA_W  registered output port, written at IO_ADDR
halted  out  1  core stopped by HALT
retired_cnt  out  32  retired-instruction count (see Optional Feature)

Behaviour:
- One clock, clk. Reset is synchronous and active-high. Reset dominates all other events, including a reset asserted mid-handshake.
- Values on reset: pc=0, R0..R3=0, io_out=0, imem_req=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, halted=0, retired_cnt=0, state=FETCH.
- Instruction format: op[15:13], rd[12:11], rs1[10:9], rs2[8:7], imm[7:0]. imm is zero-extended.
- R0 always reads 0. Writes to R0 are discarded.
- Opcodes:
  - 000 ADD: rd=rs1+rs2
  - 001 SUB: rd=rs1-rs2
  - 010 LOAD: rd=mem[rs1+imm]
  - 011 STORE: mem[rs1+imm]=rd
  - 100 JUMP: pc=imm
  - 101 BEQZ: pc = (rs1==0) ? imm : pc+1
  - 110 ADDI: rd=rs1+imm
  - 111 HALT
- All arithmetic is modulo 2^DATA_W. pc+1 wraps modulo 2^ADDR_W.
- FSM states: FETCH, EXEC, MEM, HALTED.
  - FETCH: imem_req=1, imem_addr=pc. On the edge where imem_ack=1, latch the instruction and go to EXEC. imem_ack may be high in the first req cycle.
  - EXEC, ALU/JUMP/BEQZ: write rd, update pc, return to FETCH.
  - EXEC, LOAD/STORE: compute address. If address==IO_ADDR, complete in this same cycle (LOAD writes io_in; STORE writes io_out), pc+1, go to FETCH. Otherwise drive dmem_* and go to MEM.
  - EXEC, HALT: go to HALTED and set halted=1. Stay there until reset. pc is not advanced.
  - MEM: dmem_req=1, address/wdata/we held stable until the edge where dmem_ack=1. On that edge LOAD writes rd=dmem_rdata, pc+1, go to FETCH.
- Any ack sampled while the corresponding req=0 is ignored. req deasserts the cycle after ack.
- Minimum cycles per instruction with zero-wait ack: ALU/branch/IO=2, dmem LOAD/STORE=3.
- An instruction retires on its final EXEC or MEM edge. HALT retires on entering HALTED.

Optional Feature:
RISC_CORE_MC_RETIRE_CNT_EN
- Defined: retired_cnt increments by 1 on every instruction retirement, wraps at 2^32, and clears on reset.
- Not defined: retired_cnt is tied to 0 and no counter flops are synthesised.

Test Plan:
- Reset held 2 cycles, then released with a zero-wait ROM -> imem_req=1, imem_addr=0 on the first cycle; all outputs at their reset values during reset.
- ROM: ADDI R1,R0,5; ADDI R2,R0,3; SUB R3,R1,R2; STORE R3,0x10(R0); HALT -> one dmem write addr=0x10 data=2; halted=1; retired_cnt=5 with the macro, 0 without.
- DATA_W=16, io_in=0x1234: LOAD R1,0xFF(R0)?; IO_ADDR=0xFFFF, so use ADDI R2,R0,0xFF; ADD R2,R2,R2… then LOAD from IO_ADDR -> R1=0x1234, no dmem_req pulse; STORE to IO_ADDR -> io_out updates, no dmem_req.
- dmem_ack delayed 3 cycles on a LOAD -> dmem_req, addr and we stable for 4 cycles; rd updated only on the ack edge; a spurious ack while idle has no effect.
- BEQZ with R1=0 -> pc=imm; with R1=7 -> pc+1. PC at 0xFF with ADDW=8 -> wraps to 0x00. ADDI R0,R0,9 -> R0 still reads 0.
- Reset asserted during a MEM wait -> next cycle dmem_req=0, pc=0, state=FETCH, registers cleared.

Source files
------------

// File: rtl/risc_core_mc.sv
// risc_core_mc: multi-cycle RISC core with req/ack instruction and data memory ports.
// Optional retirement counter is built when RISC_CORE_MC_RETIRE_CNT_EN is defined.
module risc_core_mc #(
  parameter int unsigned       DATA_W  = 8,
  parameter int unsigned       ADDR_W  = 8,
  parameter logic [DATA_W-1:0] IO_ADDR = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_ack,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] io_in,
  output logic [DATA_W-1:0] io_out,
  output logic              halted,
  output logic [31:0]       retired_cnt
);

  localparam int unsigned INSTR_W = 16;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_LOAD  = 3'd2;
  localparam logic [2:0] OP_STORE = 3'd3;
  localparam logic [2:0] OP_JUMP  = 3'd4;
  localparam logic [2:0] OP_BEQZ  = 3'd5;
  localparam logic [2:0] OP_ADDI  = 3'd6;
  localparam logic [2:0] OP_HALT  = 3'd7;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALTED} state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]    rf_q [1:3];
  logic [DATA_W-1:0]    rf_d [1:3];
  logic [DATA_W-1:0]    io_out_q, io_out_d;
  logic                 halted_q, halted_d;
  logic                 imem_req_q, imem_req_d;
  logic                 dmem_req_q, dmem_req_d;
  logic                 dmem_we_q, dmem_we_d;
  logic [DATA_W-1:0]    dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0]    dmem_wdata_q, dmem_wdata_d;

  logic [2:0]           op_c;
  logic [1:0]           rd_c, rs1_c, rs2_c;
  logic [7:0]           imm_c;
  logic [DATA_W-1:0]    rf_rd_c [4];
  logic [DATA_W-1:0]    rs1_val_c, rs2_val_c, rd_val_c, ea_c;
  logic [ADDR_W-1:0]    pc_inc_c;
  logic                 wb_en_c;
  logic [DATA_W-1:0]    wb_val_c;

  assign op_c  = ir_q[15:13];
  assign rd_c  = ir_q[12:11];
  assign rs1_c = ir_q[10:9];
  assign rs2_c = ir_q[8:7];
  assign imm_c = ir_q[7:0];

  // R0 is hardwired to zero; only R1..R3 have storage.
  assign rf_rd_c[0] = '0;
  assign rf_rd_c[1] = rf_q[1];
  assign rf_rd_c[2] = rf_q[2];
  assign rf_rd_c[3] = rf_q[3];

  assign rs1_val_c = rf_rd_c[rs1_c];
  assign rs2_val_c = rf_rd_c[rs2_c];
  assign rd_val_c  = rf_rd_c[rd_c];
  assign ea_c      = rs1_val_c + DATA_W'(imm_c);
  assign pc_inc_c  = pc_q + ADDR_W'(1);

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    rf_d         = rf_q;
    io_out_d     = io_out_q;
    halted_d     = halted_q;
    imem_req_d   = imem_req_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    wb_en_c      = 1'b0;
    wb_val_c     = '0;

    unique case (state_q)
      S_FETCH: begin
        if (imem_req_q && imem_ack) begin
          ir_d       = imem_rdata;
          imem_req_d = 1'b0;
          state_d    = S_EXEC;
        end else begin
          imem_req_d = 1'b1;
        end
      end
      S_EXEC: begin
        state_d    = S_FETCH;
        imem_req_d = 1'b1;
        pc_d       = pc_inc_c;
        unique case (op_c)
          OP_ADD: begin
            wb_en_c  = 1'b1;
            wb_val_c = rs1_val_c + rs2_val_c;
          end
          OP_SUB: begin
            wb_en_c  = 1'b1;
            wb_val_c = rs1_val_c - rs2_val_c;
          end
          OP_ADDI: begin
            wb_en_c  = 1'b1;
            wb_val_c = rs1_val_c + DATA_W'(imm_c);
          end
          OP_JUMP: pc_d = ADDR_W'(imm_c);
          OP_BEQZ: begin
            if (rs1_val_c == '0) pc_d = ADDR_W'(imm_c);
          end
          OP_LOAD, OP_STORE: begin
            // The I/O port completes inside EXEC; everything else goes out on dmem.
            if (ea_c == IO_ADDR) begin
              if (op_c == OP_LOAD) begin
                wb_en_c  = 1'b1;
                wb_val_c = io_in;
              end else begin
                io_out_d = rd_val_c;
              end
            end else begin
              state_d      = S_MEM;
              imem_req_d   = 1'b0;
              pc_d         = pc_q;
              dmem_req_d   = 1'b1;
              dmem_we_d    = (op_c == OP_STORE);
              dmem_addr_d  = ea_c;
              dmem_wdata_d = rd_val_c;
            end
          end
          OP_HALT: begin
            state_d    = S_HALTED;
            imem_req_d = 1'b0;
            pc_d       = pc_q;
            halted_d   = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (dmem_req_q && dmem_ack) begin
          if (!dmem_we_q) begin
            wb_en_c  = 1'b1;
            wb_val_c = dmem_rdata;
          end
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          pc_d       = pc_inc_c;
          imem_req_d = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_HALTED: ;
      default: ;
    endcase

    if (wb_en_c) begin
      unique case (rd_c)
        2'd1:    rf_d[1] = wb_val_c;
        2'd2:    rf_d[2] = wb_val_c;
        2'd3:    rf_d[3] = wb_val_c;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      pc_q         <= '0;
      ir_q         <= '0;
      rf_q         <= '{default: '0};
      io_out_q     <= '0;
      halted_q     <= 1'b0;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      rf_q         <= rf_d;
      io_out_q     <= io_out_d;
      halted_q     <= halted_d;
      imem_req_q   <= imem_req_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign io_out     = io_out_q;
  assign halted     = halted_q;

`ifdef RISC_CORE_MC_RETIRE_CNT_EN
  logic        retire_c;
  logic [31:0] retired_cnt_q, retired_cnt_d;

  // Retirement is the final EXEC edge (including HALT) or the MEM ack edge.
  always_comb begin
    retire_c      = ((state_q == S_EXEC) && (state_d != S_MEM)) ||
                    ((state_q == S_MEM) && (state_d == S_FETCH));
    retired_cnt_d = retired_cnt_q + 32'(retire_c);
  end

  always_ff @(posedge clk) begin
    if (reset) retired_cnt_q <= '0;
    else       retired_cnt_q <= retired_cnt_d;
  end

  assign retired_cnt = retired_cnt_q;
`else
  assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_risc_core_mc.sv
// Bench for risc_core_mc (DATA_W=16, ADDR_W=8): an instruction-level model predicts every
// fetch address and data access; directed programs add hand-computed end results.
module tb_risc_core_mc;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_LOAD = 3'd2, OP_STORE = 3'd3;
  localparam logic [2:0] OP_JUMP = 3'd4, OP_BEQZ = 3'd5, OP_ADDI = 3'd6, OP_HALT = 3'd7;
  localparam logic [15:0] HALT_W = 16'hE000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_rdata = '0;
  logic          imem_ack = 1'b0;
  logic          dmem_req, dmem_we;
  logic [DW-1:0] dmem_addr, dmem_wdata;
  logic [DW-1:0] dmem_rdata = '0;
  logic          dmem_ack = 1'b0;
  logic [DW-1:0] io_in = '0;
  logic [DW-1:0] io_out;
  logic          halted;
  logic [31:0]   retired_cnt;

  risc_core_mc #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .io_in(io_in), .io_out(io_out), .halted(halted), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0]   rom   [256];
  logic [DW-1:0] ram   [65536];
  logic [DW-1:0] m_ram [65536];

  // Architectural model state
  logic [AW-1:0] m_pc;
  logic [DW-1:0] m_r [4];
  logic [DW-1:0] m_io;
  logic          m_halted;
  int            m_retired;
  logic          exp_dv;
  logic          exp_we;
  logic [DW-1:0] exp_addr, exp_wdata;

  int   dm_wait = 0, dcnt = 0, dlen = 0, dmax = 0, dtrans = 0, fetches = 0;
  logic spur = 1'b0;
  logic rst_at_edge = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ri(input logic [2:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs1, input logic [1:0] rs2);
    return {op, rd, rs1, rs2, 7'd0};
  endfunction

  function automatic logic [15:0] ii(input logic [2:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs1, input logic [7:0] imm);
    return {op, rd, rs1, 1'b0, imm};
  endfunction

  function automatic logic [31:0] ret_lit(input int n);
`ifdef RISC_CORE_MC_RETIRE_CNT_EN
    return 32'(n);
`else
    return 32'(n - n);
`endif
  endfunction

  function automatic logic [DW-1:0] rv(input logic [1:0] i);
    return (i == 2'd0) ? '0 : m_r[i];
  endfunction

  task automatic wr(input logic [1:0] i, input logic [DW-1:0] v);
    if (i != 2'd0) m_r[i] = v;
  endtask

  task automatic model_reset();
    m_pc = '0; m_io = '0; m_halted = 1'b0; m_retired = 0; exp_dv = 1'b0;
    for (int i = 0; i < 4; i++) m_r[i] = '0;
  endtask

  // Executes one whole instruction in the model.
  task automatic step(input logic [15:0] w);
    logic [2:0]    op;
    logic [1:0]    rd, rs1, rs2;
    logic [7:0]    imm;
    logic [DW-1:0] a, ea;
    op = w[15:13]; rd = w[12:11]; rs1 = w[10:9]; rs2 = w[8:7]; imm = w[7:0];
    a  = rv(rs1);
    ea = a + DW'(imm);
    m_retired++;
    case (op)
      OP_ADD:  begin wr(rd, a + rv(rs2)); m_pc = m_pc + 8'd1; end
      OP_SUB:  begin wr(rd, a - rv(rs2)); m_pc = m_pc + 8'd1; end
      OP_ADDI: begin wr(rd, a + DW'(imm)); m_pc = m_pc + 8'd1; end
      OP_JUMP: m_pc = imm;
      OP_BEQZ: m_pc = (a == '0) ? imm : m_pc + 8'd1;
      OP_LOAD: begin
        if (ea == 16'hFFFF) wr(rd, io_in);
        else begin
          wr(rd, m_ram[ea]);
          exp_dv = 1'b1; exp_we = 1'b0; exp_addr = ea; exp_wdata = '0;
        end
        m_pc = m_pc + 8'd1;
      end
      OP_STORE: begin
        if (ea == 16'hFFFF) m_io = rv(rd);
        else begin
          m_ram[ea] = rv(rd);
          exp_dv = 1'b1; exp_we = 1'b1; exp_addr = ea; exp_wdata = rv(rd);
        end
        m_pc = m_pc + 8'd1;
      end
      default: m_halted = 1'b1;
    endcase
  endtask

  initial forever begin
    @(posedge clk);
    rst_at_edge = reset;
  end

  // Compare process plus zero-wait ROM and variable-wait RAM responders.
  initial forever begin
    @(negedge clk);
    if (rst_at_edge) begin
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_imem_addr", 32'(imem_addr), 32'd0);
      chk("rst_dmem_req", 32'(dmem_req), 32'd0);
      chk("rst_dmem_we", 32'(dmem_we), 32'd0);
      chk("rst_dmem_addr", 32'(dmem_addr), 32'd0);
      chk("rst_dmem_wdata", 32'(dmem_wdata), 32'd0);
      chk("rst_io_out", 32'(io_out), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_retired", retired_cnt, 32'd0);
      model_reset();
      imem_ack = 1'b0; dmem_ack = 1'b0; dcnt = 0; dlen = 0;
    end else begin
      if (imem_req) begin
        chk("fetch_pc", 32'(imem_addr), 32'(m_pc));
        chk("fetch_io_out", 32'(io_out), 32'(m_io));
        chk("fetch_halted", 32'(halted), 32'd0);
        chk("fetch_retired", retired_cnt, ret_lit(m_retired));
        chk("fetch_dmem_done", 32'(exp_dv), 32'd0);
        imem_rdata = rom[imem_addr];
        imem_ack   = 1'b1;
        fetches++;
        step(rom[imem_addr]);
      end else begin
        imem_ack   = spur;
        imem_rdata = HALT_W;
      end
      if (dmem_req) begin
        dlen++;
        chk("dmem_expected", 32'(exp_dv), 32'd1);
        chk("dmem_addr", 32'(dmem_addr), 32'(exp_addr));
        chk("dmem_we", 32'(dmem_we), 32'(exp_we));
        if (exp_we) chk("dmem_wdata", 32'(dmem_wdata), 32'(exp_wdata));
        if (dcnt >= dm_wait) begin
          dmem_ack = 1'b1;
          if (dmem_we) ram[dmem_addr] = dmem_wdata;
          else         dmem_rdata = ram[dmem_addr];
          if (dlen > dmax) dmax = dlen;
          dtrans++;
          exp_dv = 1'b0;
          dcnt   = 0;
        end else begin
          dmem_ack = 1'b0;
          dcnt++;
        end
      end else begin
        dmem_ack   = spur;
        dmem_rdata = 16'hDEAD;
        dlen = 0;
        dcnt = 0;
      end
    end
  end

  task automatic preset(input logic [15:0] a, input logic [DW-1:0] v);
    ram[a] = v; m_ram[a] = v;
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = HALT_W;
  endtask

  task automatic enter_reset();
    @(negedge clk); #2 reset = 1'b1;
    @(posedge clk); #1;
    fetches = 0; dtrans = 0; dmax = 0;
  endtask

  task automatic leave_reset();
    @(posedge clk);
    @(negedge clk); #2 reset = 1'b0;
  endtask

  task automatic wait_halt(input string name, input int budget);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_halted"}, 32'(halted), 32'd1);
    chk({name, "_model_halted"}, 32'(m_halted), 32'd1);
    chk({name, "_retired_model"}, retired_cnt, ret_lit(m_retired));
    chk({name, "_io_out_model"}, 32'(io_out), 32'(m_io));
    chk({name, "_dmem_idle"}, 32'(exp_dv), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) begin ram[i] = '0; m_ram[i] = '0; end

    // Program 1: arithmetic then one dmem store
    rom_clear();
    rom[0] = ii(OP_ADDI, 2'd1, 2'd0, 8'd5);
    rom[1] = ii(OP_ADDI, 2'd2, 2'd0, 8'd3);
    rom[2] = ri(OP_SUB, 2'd3, 2'd1, 2'd2);
    rom[3] = ii(OP_STORE, 2'd3, 2'd0, 8'h10);
    rom[4] = HALT_W;
    repeat (2) @(posedge clk);
    @(negedge clk); #2 reset = 1'b0;
    @(posedge clk); #1;
    chk("first_fetch_req", 32'(imem_req), 32'd1);
    chk("first_fetch_addr", 32'(imem_addr), 32'd0);
    wait_halt("p1", 200);
    chk("p1_ram10", 32'(ram[16'h10]), 32'd2);
    chk("p1_dmem_trans", 32'(dtrans), 32'd1);
    chk("p1_retired_lit", retired_cnt, ret_lit(5));

    // Program 2: I/O load and store at 0xFFFF, no dmem traffic for them
    enter_reset();
    rom_clear();
    io_in  = 16'h1234;
    rom[0] = ii(OP_ADDI, 2'd3, 2'd0, 8'd1);
    rom[1] = ri(OP_SUB, 2'd2, 2'd0, 2'd3);
    rom[2] = ii(OP_LOAD, 2'd1, 2'd2, 8'd0);
    rom[3] = ii(OP_ADDI, 2'd1, 2'd1, 8'd1);
    rom[4] = ii(OP_STORE, 2'd1, 2'd2, 8'd0);
    rom[5] = ii(OP_STORE, 2'd1, 2'd0, 8'h11);
    leave_reset();
    wait_halt("p2", 200);
    chk("p2_io_out", 32'(io_out), 32'h1235);
    chk("p2_ram11", 32'(ram[16'h11]), 32'h1235);
    chk("p2_dmem_trans", 32'(dtrans), 32'd1);

    // Program 3: 3-cycle dmem wait and spurious acks while idle
    enter_reset();
    rom_clear();
    preset(16'h42, 16'h0ABC);
    dm_wait = 3;
    spur    = 1'b1;
    rom[0] = ii(OP_ADDI, 2'd1, 2'd0, 8'h40);
    rom[1] = ii(OP_LOAD, 2'd2, 2'd1, 8'h02);
    rom[2] = ri(OP_ADD, 2'd3, 2'd2, 2'd2);
    rom[3] = ii(OP_STORE, 2'd3, 2'd0, 8'h50);
    leave_reset();
    wait_halt("p3", 300);
    chk("p3_ram50", 32'(ram[16'h50]), 32'h1578);
    chk("p3_req_len", 32'(dmax), 32'd4);
    chk("p3_dmem_trans", 32'(dtrans), 32'd2);
    spur    = 1'b0;

    // Program 4: branches, R0 write discard, pc wrap 0xFF -> 0x00
    enter_reset();
    rom_clear();
    dm_wait = 0;
    preset(16'h61, 16'hBEEF);
    rom[8'h00] = ii(OP_BEQZ, 2'd0, 2'd3, 8'h08);
    rom[8'h01] = ii(OP_STORE, 2'd3, 2'd0, 8'h60);
    rom[8'h08] = ii(OP_ADDI, 2'd2, 2'd0, 8'd7);
    rom[8'h09] = ii(OP_BEQZ, 2'd0, 2'd1, 8'h0C);
    rom[8'h0C] = ii(OP_BEQZ, 2'd0, 2'd2, 8'h00);
    rom[8'h0D] = ii(OP_ADDI, 2'd0, 2'd0, 8'd9);
    rom[8'h0E] = ii(OP_STORE, 2'd0, 2'd0, 8'h61);
    rom[8'h0F] = ii(OP_JUMP, 2'd0, 2'd0, 8'hFE);
    rom[8'hFE] = ii(OP_ADDI, 2'd3, 2'd0, 8'h33);
    rom[8'hFF] = ii(OP_ADDI, 2'd3, 2'd3, 8'd1);
    leave_reset();
    wait_halt("p4", 400);
    chk("p4_ram60", 32'(ram[16'h60]), 32'h34);
    chk("p4_r0_zero", 32'(ram[16'h61]), 32'd0);
    chk("p4_fetches", 32'(fetches), 32'd12);
    chk("p4_retired_lit", retired_cnt, ret_lit(12));

    // Program 5: reset lands in the middle of a long dmem wait
    enter_reset();
    rom_clear();
    dm_wait = 20;
    rom[0] = ii(OP_ADDI, 2'd1, 2'd0, 8'h55);
    rom[1] = ii(OP_LOAD, 2'd2, 2'd0, 8'h30);
    leave_reset();
    n = 0;
    while (dmem_req !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("p5_mem_entered", 32'(dmem_req), 32'd1);
    chk("p5_pc_in_mem", 32'(imem_addr), 32'd1);
    @(negedge clk);
    @(negedge clk); #2 reset = 1'b1;
    @(posedge clk); #1;
    chk("p5_rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("p5_rst_pc", 32'(imem_addr), 32'd0);
    chk("p5_rst_imem_req", 32'(imem_req), 32'd0);
    fetches = 0; dtrans = 0; dmax = 0;
    rom_clear();
    dm_wait = 0;
    preset(16'h20, 16'hBEEF);
    rom[0] = ii(OP_STORE, 2'd1, 2'd0, 8'h20);
    leave_reset();
    wait_halt("p5", 200);
    chk("p5_r1_cleared", 32'(ram[16'h20]), 32'd0);
    chk("p5_dmem_trans", 32'(dtrans), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
